fp32_mul_pipe: RTL and testbench

//  IEEE-754 binary32 multiplier: FP_out = FP_A * FP_B, round-to-nearest-even.
//  Two-stage pipeline, one result per cycle, no backpressure.

---
 rtl/fp32_pkg.sv | 49 ++++
 rtl/fp_mant_mul.sv | 21 ++
 rtl/fp32_mul_pipe.sv | 158 +++++++++++++++
 tb/tb_fp32_mul_pipe.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared field widths, constants, operand record and unpack helper for the fp32 multiplier.
// Honours DENORM_EN: when defined, subnormal operands are unpacked with a hidden 0 and exponent 1.
package fp32_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = FRAC_W + 1;
    localparam int BIAS   = 127;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
        logic              is_zero;
        logic              is_inf;
        logic              is_nan;
    } fp_unpacked_t;

    typedef enum logic [1:0] {
        SP_NONE,
        SP_NAN,
        SP_INF,
        SP_ZERO
    } special_t;

    function automatic fp_unpacked_t fp_unpack(input logic [31:0] x);
        fp_unpacked_t u;
        u.sign    = x[31];
        u.exp     = x[30:23];
        u.mant    = {1'b1, x[22:0]};
        u.is_nan  = (x[30:23] == 8'hFF) && (x[22:0] != '0);
        u.is_inf  = (x[30:23] == 8'hFF) && (x[22:0] == '0);
        u.is_zero = 1'b0;
        if (x[30:23] == '0) begin
`ifdef DENORM_EN
            u.exp     = 8'd1;
            u.mant    = {1'b0, x[22:0]};
            u.is_zero = (x[22:0] == '0);
`else
            u.is_zero = 1'b1;
`endif
        end
        return u;
    endfunction

endpackage

// File: rtl/fp_mant_mul.sv
// Registered 24x24 unsigned mantissa multiplier; acts as the first-stage product register.
module fp_mant_mul
    import fp32_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [MANT_W-1:0]   a,
    input  logic [MANT_W-1:0]   b,
    output logic [2*MANT_W-1:0] prod
);

    // NOTE: sequential state is always written with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!rst_n)
            prod <= '0;
        else if (en)
            prod <= (2*MANT_W)'(a) * (2*MANT_W)'(b);
    end

endmodule

// File: rtl/fp32_mul_pipe.sv
// Two-stage IEEE-754 binary32 multiplier with round-to-nearest-even.
// Build option DENORM_EN: gradual underflow instead of flush-to-zero.
module fp32_mul_pipe
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] FP_A,
    input  logic [31:0] FP_B,
    output logic        out_valid,
    output logic [31:0] FP_out
);

    fp_unpacked_t a_u, b_u;
    special_t     sp_next, s1_special;
    logic                s1_valid, s1_sign;
    logic signed [9:0]   s1_exp;
    logic [47:0]         prod;

    assign a_u = fp_unpack(FP_A);
    assign b_u = fp_unpack(FP_B);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sp_next = SP_NONE;
        if (a_u.is_nan || b_u.is_nan)
            sp_next = SP_NAN;
        else if ((a_u.is_inf && b_u.is_zero) || (a_u.is_zero && b_u.is_inf))
            sp_next = SP_NAN;
        else if (a_u.is_inf || b_u.is_inf)
            sp_next = SP_INF;
        else if (a_u.is_zero || b_u.is_zero)
            sp_next = SP_ZERO;
    end

    // NOTE: all pipeline registers are reset so a reset drops in-flight products.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_exp     <= '0;
            s1_special <= SP_NONE;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign    <= a_u.sign ^ b_u.sign;
                s1_exp     <= $signed({2'b00, a_u.exp}) + $signed({2'b00, b_u.exp}) - 10'(BIAS);
                s1_special <= sp_next;
            end
        end
    end

    fp_mant_mul u_mant_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_valid),
        .a     (a_u.mant),
        .b     (b_u.mant),
        .prod  (prod)
    );

    logic [47:0]       norm_m, sub_m;
    logic signed [9:0] norm_e, final_e;
    logic [5:0]        lsh;
    logic              is_sub, sub_sticky, guard, sticky, round_up;
    logic [24:0]       rounded;
    logic [22:0]       frac;
    logic [31:0]       result;
`ifdef DENORM_EN
    logic [5:0]        lz, rsh_u;
    logic signed [9:0] rsh;

    always_comb begin
        lz = 6'd47;
        for (int i = 0; i <= 46; i++)
            if (prod[i]) lz = 6'(46 - i);
    end
`endif

    always_comb begin
        lsh        = '0;
        is_sub     = 1'b0;
        sub_sticky = 1'b0;
`ifdef DENORM_EN
        rsh   = '0;
        rsh_u = '0;
        // Lift products of subnormal operands, but never below exponent 1.
        if (!prod[47] && s1_exp > 10'sd1) begin
            if (s1_exp - 10'sd1 > $signed({4'b0000, lz}))
                lsh = lz;
            else
                lsh = s1_exp[5:0] - 6'd1;
        end
`endif
        if (prod[47]) begin
            norm_m = prod;
            norm_e = s1_exp + 10'sd1;
        end else begin
            norm_m = prod << (lsh + 6'd1);
            norm_e = s1_exp - $signed({4'b0000, lsh});
        end

        sub_m = norm_m;
`ifdef DENORM_EN
        if (norm_e < 10'sd1) begin
            is_sub = 1'b1;
            rsh    = 10'sd1 - norm_e;
            if (rsh > 10'sd48) begin
                sub_m      = '0;
                sub_sticky = |norm_m;
            end else begin
                rsh_u      = rsh[5:0];
                sub_m      = norm_m >> rsh_u;
                sub_sticky = |(norm_m & ~({48{1'b1}} << rsh_u));
            end
        end
`endif

        guard    = sub_m[23];
        sticky   = (|sub_m[22:0]) | sub_sticky;
        round_up = guard & (sticky | sub_m[24]);
        rounded  = {1'b0, sub_m[47:24]} + 25'(round_up);

        // A subnormal that rounds up to 1.0 lands exactly on the smallest normal.
        if (is_sub)
            final_e = rounded[23] ? 10'sd1 : 10'sd0;
        else
            final_e = norm_e + (rounded[24] ? 10'sd1 : 10'sd0);
        frac = rounded[24] ? rounded[23:1] : rounded[22:0];

        unique case (s1_special)
            SP_NAN:  result = QNAN;
            SP_INF:  result = {s1_sign, POS_INF[30:0]};
            SP_ZERO: result = {s1_sign, 31'h0};
            default: begin
                if (final_e >= 10'sd255)
                    result = {s1_sign, POS_INF[30:0]};
                else if (!is_sub && final_e <= 10'sd0)
                    result = {s1_sign, 31'h0};
                else
                    result = {s1_sign, final_e[7:0], frac};
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            FP_out    <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid)
                FP_out <= result;
        end
    end

endmodule

// File: tb/tb_fp32_mul_pipe.sv
// Self-checking bench for fp32_mul_pipe: directed vectors plus random operands against an
// exact integer-arithmetic RNE reference; honours DENORM_EN the same way as the design.
module tb_fp32_mul_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] FP_A, FP_B;
    logic        out_valid;
    logic [31:0] FP_out;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference pipeline: pending product after one edge, visible output after two.
    logic        m_pv, m_ov;
    logic [31:0] m_pd, m_od;

    always #5 clk = ~clk;

    fp32_mul_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .FP_A      (FP_A),
        .FP_B      (FP_B),
        .out_valid (out_valid),
        .FP_out    (FP_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, expv);
        end
    endtask

    // Round m / 2^sh to an integer, ties to even; negative sh scales up exactly.
    function automatic logic [63:0] rne(input logic [63:0] m, input int sh);
        logic [63:0] q, rem, half;
        if (sh <= 0) return m << (-sh);
        if (sh > 60) return 64'd0;
        q    = m >> sh;
        rem  = m & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        return q;
    endfunction

    // Exact value of each operand is M * 2^E; the product is rounded to binary32.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s, na, nb, ia, ib, za, zb;
        logic [63:0] ma, mb, m, q;
        int          ea, eb, e, k, be;
        s  = a[31] ^ b[31];
        na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        ia = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        ib = (b[30:23] == 8'hFF) && (b[22:0] == 0);
`ifdef DENORM_EN
        za = (a[30:0] == 0);
        zb = (b[30:0] == 0);
`else
        za = (a[30:23] == 0);
        zb = (b[30:23] == 0);
`endif
        if (na || nb) return 32'h7FC00000;
        if ((ia && zb) || (za && ib)) return 32'h7FC00000;
        if (ia || ib) return {s, 8'hFF, 23'h0};
        if (za || zb) return {s, 31'h0};
        ma = (a[30:23] == 0) ? {41'd0, a[22:0]} : {40'd0, 1'b1, a[22:0]};
        mb = (b[30:23] == 0) ? {41'd0, b[22:0]} : {40'd0, 1'b1, b[22:0]};
        ea = (a[30:23] == 0) ? -149 : int'(a[30:23]) - 150;
        eb = (b[30:23] == 0) ? -149 : int'(b[30:23]) - 150;
        m  = ma * mb;
        e  = ea + eb;
        k  = 0;
        for (int i = 0; i < 64; i++) if (m[i]) k = i;
        be = k + e + 127;
`ifdef DENORM_EN
        if (be < 1) begin
            q = rne(m, -149 - e);
            return {s, q[30:0]};
        end
`endif
        q = rne(m, k - 23);
        if (q[24]) begin
            q  = q >> 1;
            be = be + 1;
        end
        if (be >= 255) return {s, 8'hFF, 23'h0};
        if (be <= 0) return {s, 31'h0};
        return {s, 8'(be), q[22:0]};
    endfunction

    // One clock: drive at the falling edge, advance the reference at the rising edge, check after.
    task automatic step(input bit r, input bit v, input logic [31:0] a, input logic [31:0] b,
                        input bit use_lit, input logic [31:0] lit);
        @(negedge clk);
        rst_n    = ~r;
        in_valid = v;
        FP_A     = a;
        FP_B     = b;
        @(posedge clk);
        cyc++;
        if (r) begin
            m_pv = 1'b0; m_ov = 1'b0; m_pd = '0; m_od = '0;
        end else begin
            m_ov = m_pv;
            if (m_pv) m_od = m_pd;
            m_pv = v;
            if (v) m_pd = use_lit ? lit : ref_mul(a, b);
        end
        #1;
        check("out_valid", {31'h0, out_valid}, {31'h0, m_ov});
        check("FP_out", FP_out, m_od);
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b);
        step(1'b0, 1'b1, a, b, 1'b0, 32'h0);
    endtask

    task automatic drive_exp(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
        step(1'b0, 1'b1, a, b, 1'b1, expv);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom, $urandom, 1'b0, 32'h0);
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0:       r[30:23] = 8'h00;
            1:       r[30:23] = 8'hFF;
            2, 3:    r[30:23] = 8'($urandom_range(1, 40));
            4:       r[30:23] = 8'($urandom_range(200, 254));
            5:       r[30:23] = 8'($urandom_range(50, 76));
            default: r[30:23] = 8'($urandom_range(100, 154));
        endcase
        if ($urandom_range(0, 7) == 0) r[22:0] = '0;
        return r;
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; FP_A = '0; FP_B = '0;
        m_pv = 1'b0; m_ov = 1'b0; m_pd = '0; m_od = '0;

        // Reset state
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 32'h0);
        idle(2);

        // Single product, latency visible through the per-cycle checks
        drive(32'h40270A3D, 32'h3E947AE1);
        idle(3);

        // Back-to-back stream
        drive(32'h3FC7AE14, 32'h3F9D70A4);
        drive(32'h43038F5C, 32'h436AC7AE);
        drive(32'h3FC7AE14, 32'h3FAF5C29);
        idle(3);

        // Exact results and specials
        drive_exp(32'h3FC00000, 32'h40000000, 32'h40400000);
        drive_exp(32'hBF800000, 32'h3F800000, 32'hBF800000);
        drive_exp(32'h7F800000, 32'h00000000, 32'h7FC00000);
        drive_exp(32'hFF800000, 32'h40000000, 32'hFF800000);
        drive_exp(32'h7FC00000, 32'h3F800000, 32'h7FC00000);
        drive_exp(32'h7FC00000, 32'h7F800000, 32'h7FC00000);
        drive_exp(32'h80000000, 32'h3F800000, 32'h80000000);
        drive_exp(32'h7F7FFFFF, 32'h40000000, 32'h7F800000);
`ifdef DENORM_EN
        drive_exp(32'h00800000, 32'h3F000000, 32'h00400000);
`else
        drive_exp(32'h00800000, 32'h3F000000, 32'h00000000);
`endif
        // Rounding ties and carry-out into the next binade
        drive(32'h3F800001, 32'h3F800001);
        drive(32'h3FFFFFFF, 32'h3FFFFFFF);
        drive(32'h3F7FFFFF, 32'h00800000);
        idle(3);

        // Random operands with random gaps
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) != 0)
                drive(rand_op(), rand_op());
            else
                idle(1);
        end
        idle(3);

        // Reset with two products in flight; none may appear afterwards
        drive(32'h40400000, 32'h40400000);
        drive(32'h40A00000, 32'h40A00000);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        idle(4);
        drive(32'h3FC00000, 32'h3FC00000);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
